multi_lift_status_collector: RTL and testbench

- Return path of the multi-lift arbitration scheme: the arbiter forwards floor requests down to the per-lift controllers; this block collects their status back up to the top level.
- Latches hall calls from the top level into pending lamps, then clears each one when any lift opens its doors at that floor.
- Serialises per-lift arrival events into a valid/ready report stream toward the top-level dispatcher, using round-robin fairness across lifts.

---
 rtl/multi_lift_status_collector.sv | 198 +++++++++++++++++++
 tb/tb_multi_lift_status_collector.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_lift_status_collector.sv
// multi_lift_status_collector
// Collects per-lift status for the top level of the multi-lift scheme:
//  - latches hall calls into pending lamps, cleared when a lift opens its
//    doors at that floor (clear beats a same-cycle set),
//  - captures per-lift door-open rising edges as arrival events and
//    serialises them, round-robin across lifts, onto a valid/ready report
//    stream.
// Optional build macro LIFT_RPT_OVERRUN_EN adds an 8-bit saturating
// overrun_cnt output counting cycles in which an arrival overwrote a
// still-unreported pending entry.
module multi_lift_status_collector #(
   parameter int N_FLOORS = 12,
   parameter int N_LIFTS  = 10,
   parameter int FLR_W    = $clog2(N_FLOORS),
   parameter int LIFT_W   = $clog2(N_LIFTS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_LIFTS*FLR_W-1:0] lift_flr,
   input  logic [N_LIFTS-1:0]       lift_door_open,
   input  logic [N_FLOORS-1:0]      hall_call,
   output logic [N_FLOORS-1:0]      hall_pending,
   output logic                     rpt_valid,
   input  logic                     rpt_ready,
   output logic [LIFT_W-1:0]        rpt_lift,
   output logic [FLR_W-1:0]         rpt_flr
`ifdef LIFT_RPT_OVERRUN_EN
   ,
   output logic [7:0]               overrun_cnt
`endif
);

   typedef enum logic {
      ST_IDLE,
      ST_SEND
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [N_LIFTS-1:0]  r_door_q;
   logic [N_LIFTS-1:0]  w_arr;
   logic [N_LIFTS-1:0]  r_arr_pend;
   logic [FLR_W-1:0]    r_arr_flr [N_LIFTS];

   logic [N_FLOORS-1:0] r_hall_pending;
   logic [N_FLOORS-1:0] w_hall_clr;

   logic [LIFT_W-1:0]   r_rr_ptr;
   logic [LIFT_W-1:0]   r_rpt_lift;
   logic [FLR_W-1:0]    r_rpt_flr;
   logic [LIFT_W-1:0]   w_sel;
   logic                w_found;
   logic                w_load;
   logic                w_hs;
   // The lift being reported re-arrived after its floor was latched into
   // the report; its pending bit must survive the handshake so the newer
   // floor is reported afterwards.
   logic                r_keep;

   // Arrival event: rising edge of a lift's door-open level.
   assign w_arr = lift_door_open & ~r_door_q;

   // Floors at which some lift currently has its doors open (level based).
   always_comb begin
      w_hall_clr = '0;
      for (int unsigned i = 0; i < N_LIFTS; i++) begin
         for (int unsigned f = 0; f < N_FLOORS; f++) begin
            if (lift_door_open[i] && (lift_flr[i*FLR_W +: FLR_W] == FLR_W'(f)))
               w_hall_clr[f] = 1'b1;
         end
      end
   end

   // Round-robin pick: first pending lift scanning from r_rr_ptr upward.
   always_comb begin
      int unsigned idx;
      idx     = 0;
      w_found = 1'b0;
      w_sel   = '0;
      for (int unsigned k = 0; k < N_LIFTS; k++) begin
         idx = 32'(r_rr_ptr) + k;
         if (idx >= 32'(N_LIFTS))
            idx = idx - 32'(N_LIFTS);
         if (!w_found && r_arr_pend[LIFT_W'(idx)]) begin
            w_found = 1'b1;
            w_sel   = LIFT_W'(idx);
         end
      end
   end

   // Report FSM next-state logic: load a report in IDLE, wait for handshake in SEND.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_hs        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (rpt_ready) begin
               w_hs        = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Report FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   // Report payload, round-robin pointer and re-arrival tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rpt_lift <= '0;
         r_rpt_flr  <= '0;
         r_rr_ptr   <= '0;
         r_keep     <= 1'b0;
      end else begin
         if (w_load) begin
            r_rpt_lift <= w_sel;
            r_rpt_flr  <= r_arr_flr[w_sel];
            r_keep     <= w_arr[w_sel];
         end else if ((r_state == ST_SEND) && w_arr[r_rpt_lift]) begin
            r_keep <= 1'b1;
         end
         if (w_hs)
            r_rr_ptr <= (r_rpt_lift == LIFT_W'(N_LIFTS - 1)) ? '0 : r_rpt_lift + 1'b1;
      end
   end

   // Arrival capture: newest floor always wins; pending bit cleared on handshake
   // unless the same lift re-arrived since its report was loaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_door_q   <= '0;
         r_arr_pend <= '0;
         for (int unsigned i = 0; i < N_LIFTS; i++)
            r_arr_flr[i] <= '0;
      end else begin
         r_door_q <= lift_door_open;
         for (int unsigned i = 0; i < N_LIFTS; i++) begin
            if (w_arr[i]) begin
               r_arr_pend[i] <= 1'b1;
               r_arr_flr[i]  <= lift_flr[i*FLR_W +: FLR_W];
            end else if (w_hs && (r_rpt_lift == LIFT_W'(i)) && !r_keep) begin
               r_arr_pend[i] <= 1'b0;
            end
         end
      end
   end

   // Hall lamps: set by calls, cleared by any open door at that floor (clear wins).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_hall_pending <= '0;
      else
         r_hall_pending <= (r_hall_pending | hall_call) & ~w_hall_clr;
   end

`ifdef LIFT_RPT_OVERRUN_EN
   logic [N_LIFTS-1:0] w_hs_mask;
   logic [7:0]         r_overrun_cnt;

   // Entry being handshaken this cycle is not an overwrite of unreported data.
   always_comb begin
      w_hs_mask = '0;
      if (w_hs)
         w_hs_mask[r_rpt_lift] = 1'b1;
   end

   // Saturating count of cycles with at least one overwritten pending entry.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         r_overrun_cnt <= '0;
      else if ((|(w_arr & r_arr_pend & ~w_hs_mask)) && (r_overrun_cnt != 8'hFF))
         r_overrun_cnt <= r_overrun_cnt + 8'd1;
   end

   assign overrun_cnt = r_overrun_cnt;
`endif

   assign hall_pending = r_hall_pending;
   assign rpt_valid    = (r_state == ST_SEND);
   assign rpt_lift     = r_rpt_lift;
   assign rpt_flr      = r_rpt_flr;

endmodule

// File: tb/tb_multi_lift_status_collector.sv
// Self-checking bench for multi_lift_status_collector: directed scenarios
// with constant expectations, then randomized traffic compared every cycle
// against a behavioural model of the collector.
module tb_multi_lift_status_collector;

   localparam int N_FLOORS = 12;
   localparam int N_LIFTS  = 10;
   localparam int FLR_W    = 4;
   localparam int LIFT_W   = 4;

   logic                     clk = 1'b0;
   logic                     rst_n = 1'b0;
   logic [N_LIFTS*FLR_W-1:0] lift_flr = '0;
   logic [N_LIFTS-1:0]       lift_door_open = '0;
   logic [N_FLOORS-1:0]      hall_call = '0;
   logic [N_FLOORS-1:0]      hall_pending;
   logic                     rpt_valid;
   logic                     rpt_ready = 1'b0;
   logic [LIFT_W-1:0]        rpt_lift;
   logic [FLR_W-1:0]         rpt_flr;
`ifdef LIFT_RPT_OVERRUN_EN
   logic [7:0]               overrun_cnt;
`endif

   int checks = 0;
   int failures = 0;

   multi_lift_status_collector #(
      .N_FLOORS(N_FLOORS),
      .N_LIFTS (N_LIFTS)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .lift_flr      (lift_flr),
      .lift_door_open(lift_door_open),
      .hall_call     (hall_call),
      .hall_pending  (hall_pending),
      .rpt_valid     (rpt_valid),
      .rpt_ready     (rpt_ready),
      .rpt_lift      (rpt_lift),
      .rpt_flr       (rpt_flr)
`ifdef LIFT_RPT_OVERRUN_EN
      ,
      .overrun_cnt   (overrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   bit [N_LIFTS-1:0]  m_pend, m_door_q, m_arr;
   int                m_flr [N_LIFTS];
   bit [N_FLOORS-1:0] m_hall;
   int                m_rr, m_sel, m_rflr, m_ovr;
   bit                m_busy, m_keep, m_hs, m_ov, m_clr, m_found;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_pend = '0; m_door_q = '0; m_hall = '0;
         m_rr = 0; m_sel = 0; m_rflr = 0; m_ovr = 0;
         m_busy = 0; m_keep = 0;
         for (int i = 0; i < N_LIFTS; i++) m_flr[i] = 0;
      end else begin
         m_arr = lift_door_open & ~m_door_q;
         m_hs  = m_busy && rpt_ready;
         m_ov  = 0;
         for (int i = 0; i < N_LIFTS; i++)
            if (m_arr[i] && m_pend[i] && !(m_hs && i == m_sel)) m_ov = 1;
         if (m_ov && m_ovr < 255) m_ovr++;
         for (int f = 0; f < N_FLOORS; f++) begin
            m_clr = 0;
            for (int i = 0; i < N_LIFTS; i++)
               if (lift_door_open[i] && int'(lift_flr[i*FLR_W +: FLR_W]) == f) m_clr = 1;
            m_hall[f] = (m_hall[f] | hall_call[f]) & !m_clr;
         end
         if (m_busy) begin
            if (rpt_ready) begin
               if (!(m_keep || m_arr[m_sel])) m_pend[m_sel] = 0;
               m_rr   = (m_sel + 1) % N_LIFTS;
               m_busy = 0;
            end else if (m_arr[m_sel]) begin
               m_keep = 1;
            end
         end else begin
            m_found = 0;
            for (int k = 0; k < N_LIFTS; k++) begin
               if (!m_found && m_pend[(m_rr + k) % N_LIFTS]) begin
                  m_found = 1;
                  m_sel   = (m_rr + k) % N_LIFTS;
               end
            end
            if (m_found) begin
               m_busy = 1;
               m_rflr = m_flr[m_sel];
               m_keep = m_arr[m_sel];
            end
         end
         for (int i = 0; i < N_LIFTS; i++)
            if (m_arr[i]) begin
               m_pend[i] = 1;
               m_flr[i]  = int'(lift_flr[i*FLR_W +: FLR_W]);
            end
         m_door_q = lift_door_open;
      end
   end

   task automatic set_flr(input int lift, input int flr);
      lift_flr[lift*FLR_W +: FLR_W] = FLR_W'(flr);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", rpt_valid); end
      checks++; if (rpt_lift !== 4'd0) begin failures++; $display("FAIL reset_lift: got %0d expected 0", rpt_lift); end
      checks++; if (rpt_flr !== 4'd0) begin failures++; $display("FAIL reset_flr: got %0d expected 0", rpt_flr); end
      checks++; if (hall_pending !== 12'h000) begin failures++; $display("FAIL reset_hall: got %h expected 000", hall_pending); end
      rst_n = 1'b1;
   endtask

   task automatic test_hall();
      rpt_ready = 1'b1;
      hall_call = 12'h020;
      @(negedge clk);
      hall_call = '0;
      checks++; if (hall_pending !== 12'h020) begin failures++; $display("FAIL hall_set: got %h expected 020", hall_pending); end
      set_flr(3, 5); lift_door_open[3] = 1'b1;
      @(negedge clk);
      checks++; if (hall_pending !== 12'h000) begin failures++; $display("FAIL hall_clear: got %h expected 000", hall_pending); end
      repeat (5) @(negedge clk);
      lift_door_open[3] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single();
      rpt_ready = 1'b1;
      set_flr(2, 7); lift_door_open[2] = 1'b1;
      @(negedge clk);
      checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL single_early: got %0b expected 0", rpt_valid); end
      @(negedge clk);
      checks++; if (rpt_valid !== 1'b1) begin failures++; $display("FAIL single_valid: got %0b expected 1", rpt_valid); end
      checks++; if (rpt_lift !== 4'd2) begin failures++; $display("FAIL single_lift: got %0d expected 2", rpt_lift); end
      checks++; if (rpt_flr !== 4'd7) begin failures++; $display("FAIL single_flr: got %0d expected 7", rpt_flr); end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL single_once: cycle %0d got %0b expected 0", c, rpt_valid); end
      end
      lift_door_open[2] = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_round_robin();
      bit exp_v [6] = '{1, 0, 1, 0, 1, 0};
      int exp_l [6] = '{8, 0, 1, 0, 4, 0};
      int exp_f [6] = '{2, 0, 10, 0, 11, 0};
      rpt_ready = 1'b1;
      // A lone report from lift 4 leaves the pointer at lift 5.
      set_flr(4, 0); lift_door_open[4] = 1'b1;
      repeat (4) @(negedge clk);
      lift_door_open[4] = 1'b0;
      @(negedge clk);
      set_flr(1, 10); set_flr(4, 11); set_flr(8, 2);
      lift_door_open = 10'b01_0001_0010;
      @(negedge clk);
      checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL rr_early: got %0b expected 0", rpt_valid); end
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (rpt_valid !== exp_v[c] || (exp_v[c] && (rpt_lift !== LIFT_W'(exp_l[c]) || rpt_flr !== FLR_W'(exp_f[c])))) begin
            failures++;
            $display("FAIL rr_order: step %0d got v=%0b lift=%0d flr=%0d expected v=%0b lift=%0d flr=%0d",
                     c, rpt_valid, rpt_lift, rpt_flr, exp_v[c], exp_l[c], exp_f[c]);
         end
      end
      lift_door_open = '0;
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rpt_ready = 1'b0;
      set_flr(0, 2); lift_door_open[0] = 1'b1;
      repeat (2) @(negedge clk);
      for (int c = 0; c < 10; c++) begin
         if (c == 1) begin set_flr(6, 3); lift_door_open[6] = 1'b1; end
         if (c == 3) lift_door_open[6] = 1'b0;
         if (c == 5) begin set_flr(6, 9); lift_door_open[6] = 1'b1; end
         checks++;
         if (rpt_valid !== 1'b1 || rpt_lift !== 4'd0 || rpt_flr !== 4'd2) begin
            failures++;
            $display("FAIL bp_hold: cycle %0d got v=%0b lift=%0d flr=%0d expected v=1 lift=0 flr=2", c, rpt_valid, rpt_lift, rpt_flr);
         end
         @(negedge clk);
      end
      rpt_ready = 1'b1;
      @(negedge clk);
      checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL bp_hs: got %0b expected 0", rpt_valid); end
      @(negedge clk);
      checks++;
      if (rpt_valid !== 1'b1 || rpt_lift !== 4'd6 || rpt_flr !== 4'd9) begin
         failures++;
         $display("FAIL bp_latest: got v=%0b lift=%0d flr=%0d expected v=1 lift=6 flr=9", rpt_valid, rpt_lift, rpt_flr);
      end
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL bp_single: cycle %0d got %0b expected 0", c, rpt_valid); end
      end
`ifdef LIFT_RPT_OVERRUN_EN
      checks++; if (overrun_cnt !== 8'd1) begin failures++; $display("FAIL bp_overrun: got %0d expected 1", overrun_cnt); end
`endif
      lift_door_open = '0;
      @(negedge clk);
   endtask

   task automatic test_clear_wins();
      hall_call = 12'h003;
      set_flr(0, 0); lift_door_open[0] = 1'b1;
      @(negedge clk);
      hall_call = '0;
      checks++; if (hall_pending !== 12'h002) begin failures++; $display("FAIL clear_wins: got %h expected 002", hall_pending); end
      rpt_ready = 1'b1;
      repeat (4) @(negedge clk);
      lift_door_open = '0;
      @(negedge clk);
   endtask

   task automatic test_reset_mid_send();
      rpt_ready = 1'b0;
      set_flr(5, 6); lift_door_open[5] = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (rpt_valid !== 1'b1 || rpt_lift !== 4'd5) begin failures++; $display("FAIL rms_pre: got v=%0b lift=%0d expected v=1 lift=5", rpt_valid, rpt_lift); end
      lift_door_open = '0;
      #2 rst_n = 1'b0;
      #1;
      checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL rms_drop: got %0b expected 0", rpt_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      rpt_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         checks++; if (rpt_valid !== 1'b0) begin failures++; $display("FAIL rms_stale: cycle %0d got %0b expected 0", c, rpt_valid); end
      end
   endtask

   task automatic test_random();
      int hold = 0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         for (int i = 0; i < N_LIFTS; i++) begin
            if ($urandom_range(0, 5) == 0) lift_door_open[i] = ~lift_door_open[i];
            if (!lift_door_open[i] && $urandom_range(0, 2) == 0) set_flr(i, $urandom_range(0, 15));
         end
         hall_call = ($urandom_range(0, 3) == 0) ? N_FLOORS'($urandom & $urandom) : '0;
         if (hold > 0) begin rpt_ready = 1'b0; hold--; end
         else if ($urandom_range(0, 19) == 0) begin rpt_ready = 1'b0; hold = $urandom_range(3, 12); end
         else rpt_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         checks++; if (rpt_valid !== m_busy) begin failures++; $display("FAIL rand_valid: cycle %0d got %0b expected %0b", c, rpt_valid, m_busy); end
         if (m_busy) begin
            checks++;
            if (rpt_lift !== LIFT_W'(m_sel) || rpt_flr !== FLR_W'(m_rflr)) begin
               failures++;
               $display("FAIL rand_payload: cycle %0d got lift=%0d flr=%0d expected lift=%0d flr=%0d", c, rpt_lift, rpt_flr, m_sel, m_rflr);
            end
         end
         checks++; if (hall_pending !== m_hall) begin failures++; $display("FAIL rand_hall: cycle %0d got %h expected %h", c, hall_pending, m_hall); end
`ifdef LIFT_RPT_OVERRUN_EN
         checks++; if (overrun_cnt !== 8'(m_ovr)) begin failures++; $display("FAIL rand_overrun: cycle %0d got %0d expected %0d", c, overrun_cnt, m_ovr); end
`endif
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_hall();
      test_single();
      test_round_robin();
      test_backpressure();
      test_clear_wins();
      test_reset_mid_send();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
